// File: rtl/gb_sprite_pkg.sv
// Shared encodings for the scanline sprite evaluator: FSM states, OAM byte layout,
// sprite heights and the line-offset helper used by the on-line test.
package gb_sprite_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SCAN    = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_RD_TILE = 3'd3;
  localparam logic [2:0] ST_RD_ATTR = 3'd4;
  localparam logic [2:0] ST_REQ     = 3'd5;

  localparam logic [1:0] OAM_Y    = 2'd0;
  localparam logic [1:0] OAM_X    = 2'd1;
  localparam logic [1:0] OAM_TILE = 2'd2;
  localparam logic [1:0] OAM_ATTR = 2'd3;

  localparam logic [8:0] SPR_H8  = 9'd8;
  localparam logic [8:0] SPR_H16 = 9'd16;

  // OAM Y is stored biased by 16; bit 8 set means the sprite starts below this line.
  function automatic logic [8:0] line_offset(input logic [7:0] v, input logic [7:0] y);
    return {1'b0, v} + 9'd16 - {1'b0, y};
  endfunction

endpackage

// File: rtl/sprite_slot_arb.sv
// Priority encoder over the slot match vector: lowest matching slot wins.
// Purely combinational; slot_o is 0 when nothing matches.
module sprite_slot_arb #(
  parameter int N      = 10,
  parameter int SLOT_W = 4
) (
  input  logic [N-1:0]      match_i,
  output logic              hit_o,
  output logic [SLOT_W-1:0] slot_o
);

  always_comb begin
    hit_o  = |match_i;
    slot_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (match_i[k]) begin
        slot_o = SLOT_W'(k);
      end
    end
  end

endmodule

// File: rtl/sprite_line_eval.sv
// Scanline sprite evaluator: scans OAM for sprites on v_cnt, keeps the first MAX_PER_LINE,
// then issues one req/ack fetch per kept sprite as h_cnt reaches its X coordinate.
module sprite_line_eval
  import gb_sprite_pkg::*;
#(
  parameter int OAM_ENTRIES  = 40,
  parameter int MAX_PER_LINE = 10,
  parameter int IDX_W        = 6,
  parameter int SLOT_W       = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ce_i,
  input  logic              lcd_on_i,
  input  logic              size16_i,
  input  logic              line_start_i,
  input  logic [7:0]        v_cnt_i,
  input  logic [7:0]        h_cnt_i,
  input  logic              fetch_en_i,
  output logic [7:0]        oam_addr_o,
  input  logic [7:0]        oam_q_i,
  output logic              eval_busy_o,
  output logic              eval_done_o,
  output logic              overflow_o,
  output logic              fetch_req_o,
  input  logic              fetch_ack_i,
  output logic [SLOT_W-1:0] fetch_slot_o,
  output logic [7:0]        fetch_tile_o,
  output logic [7:0]        fetch_attr_o,
  output logic [3:0]        fetch_row_o
);

  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(MAX_PER_LINE);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OAM_ENTRIES - 1);

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic                    scan_ph_q, scan_ph_d;
  logic [SLOT_W-1:0]       cnt_q, cnt_d;
  logic [MAX_PER_LINE-1:0] done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    pend_x_q, pend_x_d;
  logic [SLOT_W-1:0]       pend_slot_q, pend_slot_d;
  logic [SLOT_W-1:0]       cur_q, cur_d;
  logic [7:0]              tile_q, tile_d;
  logic [7:0]              attr_q, attr_d;
  logic [3:0]              row_q, row_d;
  logic                    req_q, req_d;

  logic [IDX_W-1:0] slot_idx_q [MAX_PER_LINE];
  logic [IDX_W-1:0] slot_idx_d [MAX_PER_LINE];
  logic [7:0]       slot_x_q   [MAX_PER_LINE];
  logic [7:0]       slot_x_d   [MAX_PER_LINE];
  logic [3:0]       slot_off_q [MAX_PER_LINE];
  logic [3:0]       slot_off_d [MAX_PER_LINE];

  logic [8:0]              scan_off;
  logic [8:0]              height;
  logic                    scan_hit;
  logic [MAX_PER_LINE-1:0] match;
  logic                    arb_hit;
  logic [SLOT_W-1:0]       arb_slot;
  logic [IDX_W-1:0]        cur_idx;
  logic [3:0]              cur_off;
  logic [3:0]              flip_off;
  logic [3:0]              row_val;
  logic [IDX_W+1:0]        addr_full;

  assign height   = size16_i ? SPR_H16 : SPR_H8;
  assign scan_off = line_offset(v_cnt_i, oam_q_i);
  assign scan_hit = !scan_off[8] && (scan_off < height);

  // A slot's done bit is only cleared once its X byte has landed, so a stale X never matches.
  always_comb begin
    for (int k = 0; k < MAX_PER_LINE; k++) begin
      match[k] = !done_q[k] && (slot_x_q[k] == h_cnt_i) && (slot_x_q[k] != 8'd0);
    end
  end

  sprite_slot_arb #(
    .N      (MAX_PER_LINE),
    .SLOT_W (SLOT_W)
  ) u_arb (
    .match_i (match),
    .hit_o   (arb_hit),
    .slot_o  (arb_slot)
  );

  assign cur_idx  = slot_idx_q[cur_q];
  assign cur_off  = slot_off_q[cur_q];
  assign flip_off = oam_q_i[6] ? ~cur_off : cur_off;
  assign row_val  = size16_i ? flip_off : {1'b0, flip_off[2:0]};

  always_comb begin
    addr_full = '0;
    case (state_q)
      ST_SCAN:    addr_full = {scan_idx_q, (scan_ph_q ? OAM_X : OAM_Y)};
      ST_RD_TILE: addr_full = {cur_idx, OAM_TILE};
      ST_RD_ATTR: addr_full = {cur_idx, OAM_ATTR};
      default:    addr_full = '0;
    endcase
  end

  assign oam_addr_o   = 8'(addr_full);
  assign eval_busy_o  = (state_q == ST_SCAN);
  assign eval_done_o  = (state_q == ST_SCAN) && scan_ph_q && (scan_idx_q == IDX_LAST);
  assign overflow_o   = overflow_q;
  assign fetch_req_o  = req_q;
  assign fetch_slot_o = cur_q;
  assign fetch_tile_o = tile_q;
  assign fetch_attr_o = attr_q;
  assign fetch_row_o  = row_q;

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    scan_ph_d   = scan_ph_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    pend_x_d    = pend_x_q;
    pend_slot_d = pend_slot_q;
    cur_d       = cur_q;
    tile_d      = tile_q;
    attr_d      = attr_q;
    row_d       = row_q;
    req_d       = req_q;
    slot_idx_d  = slot_idx_q;
    slot_x_d    = slot_x_q;
    slot_off_d  = slot_off_q;

    if (ce_i) begin
      // X byte of the entry tested last ce arrives now (one-cycle OAM read latency).
      if (pend_x_q) begin
        slot_x_d[pend_slot_q] = oam_q_i;
        done_d[pend_slot_q]   = 1'b0;
        pend_x_d              = 1'b0;
      end

      if (!lcd_on_i || line_start_i) begin
        state_d    = lcd_on_i ? ST_SCAN : ST_IDLE;
        scan_idx_d = '0;
        scan_ph_d  = 1'b0;
        cnt_d      = '0;
        done_d     = '1;
        overflow_d = 1'b0;
        pend_x_d   = 1'b0;
        req_d      = 1'b0;
        cur_d      = '0;
        tile_d     = '0;
        attr_d     = '0;
        row_d      = '0;
      end else begin
        case (state_q)
          ST_SCAN: begin
            if (!scan_ph_q) begin
              scan_ph_d = 1'b1;
            end else begin
              if (scan_hit) begin
                if (cnt_q < SLOT_MAX) begin
                  slot_idx_d[cnt_q] = scan_idx_q;
                  slot_off_d[cnt_q] = scan_off[3:0];
                  pend_x_d          = 1'b1;
                  pend_slot_d       = cnt_q;
                  cnt_d             = cnt_q + SLOT_W'(1);
                end else begin
                  overflow_d = 1'b1;
                end
              end
              scan_ph_d = 1'b0;
              if (scan_idx_q == IDX_LAST) begin
                state_d = ST_READY;
              end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
              end
            end
          end
          ST_READY: begin
            if (fetch_en_i && arb_hit) begin
              cur_d   = arb_slot;
              state_d = ST_RD_TILE;
            end
          end
          ST_RD_TILE: begin
            state_d = fetch_en_i ? ST_RD_ATTR : ST_READY;
          end
          ST_RD_ATTR: begin
            if (!fetch_en_i) begin
              state_d = ST_READY;
            end else begin
              tile_d  = size16_i ? {oam_q_i[7:1], 1'b0} : oam_q_i;
              state_d = ST_REQ;
            end
          end
          ST_REQ: begin
            if (!fetch_en_i) begin
              req_d   = 1'b0;
              state_d = ST_READY;
            end else if (!req_q) begin
              attr_d = oam_q_i;
              row_d  = row_val;
              req_d  = 1'b1;
            end else if (fetch_ack_i) begin
              done_d[cur_q] = 1'b1;
              req_d         = 1'b0;
              state_d       = ST_READY;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      scan_idx_q  <= '0;
      scan_ph_q   <= 1'b0;
      cnt_q       <= '0;
      done_q      <= '1;
      overflow_q  <= 1'b0;
      pend_x_q    <= 1'b0;
      pend_slot_q <= '0;
      cur_q       <= '0;
      tile_q      <= '0;
      attr_q      <= '0;
      row_q       <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      scan_ph_q   <= scan_ph_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      pend_x_q    <= pend_x_d;
      pend_slot_q <= pend_slot_d;
      cur_q       <= cur_d;
      tile_q      <= tile_d;
      attr_q      <= attr_d;
      row_q       <= row_d;
      req_q       <= req_d;
    end
  end

  // Slot payload is qualified by the done bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    slot_idx_q <= slot_idx_d;
    slot_x_q   <= slot_x_d;
    slot_off_q <= slot_off_d;
  end

endmodule
